// File: rtl/mem_pkg.sv
// Shared widths, depth and FSM state type for the data-memory master.
package mem_pkg;

   localparam int unsigned ADDR_W    = 14;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned MEM_DEPTH = 16;
   localparam int unsigned LEN_W     = 4;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} mem_state_t;

endpackage

// File: rtl/data_memory_master_if.sv
// Request, store-data, load-data and memory-side signals of the data-memory master.
interface data_memory_master_if;
   import mem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              busy;
   logic              err;
   logic              mem_enable;
   logic              mem_read_enable;
   logic              mem_write_enable;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_input_data;
   logic [DATA_W-1:0] mem_output_data;

   modport master (
      input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
             mem_output_data,
      output req_ready, wr_ready, rd_valid, rd_data, rd_last, busy, err, mem_enable,
             mem_read_enable, mem_write_enable, mem_address, mem_input_data
   );

   modport slave (
      output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
             mem_output_data,
      input  req_ready, wr_ready, rd_valid, rd_data, rd_last, busy, err, mem_enable,
             mem_read_enable, mem_write_enable, mem_address, mem_input_data
   );

endinterface

// File: rtl/mem_resp_fifo.sv
// Two-entry response FIFO for load data; each entry carries {last, data}.
module mem_resp_fifo
   import mem_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wptr_q, rptr_q;
   logic [1:0]       count_q;

   // Upstream credit accounting guarantees no push while full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wptr_q] <= push_data;
            wptr_q        <= ~wptr_q;
         end
         if (pop) rptr_q <= ~rptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign pop_data = mem_q[rptr_q];
   assign count    = count_q;

endmodule

// File: rtl/data_memory_master.sv
// Burst initiator for the single-port data memory (1-cycle read latency, no backpressure).
// Define MEM_BOUNDS_CHECK_EN to reject requests that run past MEM_DEPTH with an err pulse.
module data_memory_master (
   input logic                 clk,
   input logic                 rst,
   data_memory_master_if.master bus
);
   import mem_pkg::*;

   mem_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  left_q, left_d;
   logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d, en_q;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              last1_q, last1_d;
   logic              pend_q, last2_q;
   logic              err_q, err_d;
   logic [1:0]        fifo_count;
   logic [DATA_W:0]   fifo_out;
   logic              fifo_pop, idle_clear, accept, bad_req, can_issue;
   logic [2:0]        outstanding;

`ifdef MEM_BOUNDS_CHECK_EN
   logic [ADDR_W:0] end_addr;
   assign end_addr = {1'b0, bus.req_addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, bus.req_len};
   assign bad_req  = end_addr >= MEM_DEPTH[ADDR_W:0];
`else
   assign bad_req = 1'b0;
`endif

   // pend_q marks read data sitting on mem_output_data this cycle.
   assign idle_clear  = (fifo_count == 2'd0) && !rd_en_q && !pend_q;
   assign fifo_pop    = bus.rd_valid && bus.rd_ready;
   assign outstanding = {1'b0, fifo_count} + {2'b0, rd_en_q} + {2'b0, pend_q} - {2'b0, fifo_pop};
   assign can_issue   = outstanding < 3'd2;
   assign accept      = bus.req_valid && bus.req_ready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      left_d      = left_q;
      rd_en_d     = 1'b0;
      wr_en_d     = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      last1_d     = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (bad_req) begin
                  err_d = 1'b1;
               end else if (bus.req_write) begin
                  state_d = WRITE;
                  addr_d  = bus.req_addr;
                  left_d  = bus.req_len;
               end else begin
                  // First read goes out on the accept edge itself.
                  rd_en_d    = 1'b1;
                  mem_addr_d = bus.req_addr;
                  addr_d     = bus.req_addr + 1'b1;
                  last1_d    = (bus.req_len == '0);
                  left_d     = bus.req_len - 1'b1;
                  state_d    = (bus.req_len == '0) ? DRAIN : READ;
               end
            end
         end
         WRITE: begin
            if (bus.wr_valid) begin
               wr_en_d     = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = bus.wr_data;
               addr_d      = addr_q + 1'b1;
               left_d      = left_q - 1'b1;
               if (left_q == '0) state_d = IDLE;
            end
         end
         READ: begin
            if (can_issue) begin
               rd_en_d    = 1'b1;
               mem_addr_d = addr_q;
               addr_d     = addr_q + 1'b1;
               last1_d    = (left_q == '0);
               left_d     = left_q - 1'b1;
               if (left_q == '0) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (idle_clear) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         left_q      <= '0;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         en_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         last1_q     <= 1'b0;
         pend_q      <= 1'b0;
         last2_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         left_q      <= left_d;
         rd_en_q     <= rd_en_d;
         wr_en_q     <= wr_en_d;
         en_q        <= rd_en_d | wr_en_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         last1_q     <= last1_d;
         pend_q      <= rd_en_q;
         last2_q     <= last1_q;
         err_q       <= err_d;
      end
   end

   mem_resp_fifo #(
      .WIDTH(DATA_W + 1)
   ) u_resp_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (pend_q),
      .push_data({last2_q, bus.mem_output_data}),
      .pop      (fifo_pop),
      .pop_data (fifo_out),
      .count    (fifo_count)
   );

   assign bus.req_ready        = (state_q == IDLE) && idle_clear;
   assign bus.wr_ready         = (state_q == WRITE);
   assign bus.rd_valid         = (fifo_count != 2'd0);
   assign bus.rd_data          = fifo_out[DATA_W-1:0];
   assign bus.rd_last          = fifo_out[DATA_W];
   assign bus.busy             = (state_q != IDLE) || !idle_clear;
   assign bus.err              = err_q;
   assign bus.mem_enable       = en_q;
   assign bus.mem_read_enable  = rd_en_q;
   assign bus.mem_write_enable = wr_en_q;
   assign bus.mem_address      = mem_addr_q;
   assign bus.mem_input_data   = mem_wdata_q;

endmodule

// File: tb/tb_data_memory_master.sv
// Directed bench for data_memory_master: vector table of bursts plus reset and backpressure cases.
module tb_data_memory_master;
   import mem_pkg::*;

   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [DATA_W-1:0] base;
      logic              toggle;
      logic              oob;
      logic              chk_lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   data_memory_master_if bus ();
   data_memory_master dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem_model [2**ADDR_W];
   always @(posedge clk) begin
      if (bus.mem_write_enable) mem_model[bus.mem_address] <= bus.mem_input_data;
      if (bus.mem_read_enable) bus.mem_output_data <= mem_model[bus.mem_address];
   end

   int checks = 0, errors = 0;
   int cyc = 0, acc_cyc = 0, rd_strobes = 0, err_cnt = 0, overlap = 0, en_bad = 0;
   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [DATA_W-1:0] wr_data_q[$];
   logic [DATA_W-1:0] beat_data[$];
   logic              beat_last[$];
   int                rise_q[$];
   logic              prev_rv = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         prev_rv = 1'b0;
      end else begin
         if (bus.mem_write_enable) begin
            wr_addr_q.push_back(bus.mem_address);
            wr_data_q.push_back(bus.mem_input_data);
         end
         if (bus.mem_read_enable) rd_strobes++;
         if (bus.mem_read_enable && bus.mem_write_enable) overlap++;
         if (bus.mem_enable !== (bus.mem_read_enable | bus.mem_write_enable)) en_bad++;
         if (bus.err) err_cnt++;
         if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
         if (bus.rd_valid && !prev_rv) rise_q.push_back(cyc);
         if (bus.rd_valid && bus.rd_ready) begin
            beat_data.push_back(bus.rd_data);
            beat_last.push_back(bus.rd_last);
         end
         prev_rv = bus.rd_valid;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [LEN_W-1:0] len, input string name);
      int t;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_len   = len;
      t = 0;
      while (!bus.req_ready && t < 100) begin
         tick();
         t++;
      end
      check({name, "_accept"}, t < 100, 1);
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (bus.busy && t < 200) begin
         tick();
         t++;
      end
      check("idle_timeout", t < 200, 1);
      repeat (3) tick();
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   n, t, wb, bb, rb, rs, ec, nw, nr;
      logic exp_err;
      logic [ADDR_W-1:0] ea;
      n = int'(v.len) + 1;
`ifdef MEM_BOUNDS_CHECK_EN
      exp_err = v.oob;
`else
      exp_err = 1'b0;
`endif
      wb = wr_addr_q.size();
      bb = beat_data.size();
      rb = rise_q.size();
      rs = rd_strobes;
      ec = err_cnt;
      bus.rd_ready = !v.toggle;
      request(v.wr, v.addr, v.len, $sformatf("v%0d", idx));
      if (v.wr && !exp_err) begin
         for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = v.base + DATA_W'(i);
            t = 0;
            while (!bus.wr_ready && t < 50) begin
               tick();
               t++;
            end
            tick();
         end
         bus.wr_valid = 1'b0;
      end
      if (!v.wr && !exp_err) begin
         t = 0;
         while ((beat_data.size() - bb) < n && t < 300) begin
            tick();
            t++;
            if (v.toggle) bus.rd_ready = ~bus.rd_ready;
         end
         bus.rd_ready = 1'b1;
      end
      wait_idle();
      bus.rd_ready = 1'b1;

      nw = (v.wr && !exp_err) ? n : 0;
      nr = (!v.wr && !exp_err) ? n : 0;
      check($sformatf("v%0d_err_pulses", idx), err_cnt - ec, exp_err ? 1 : 0);
      check($sformatf("v%0d_wr_strobes", idx), wr_addr_q.size() - wb, nw);
      check($sformatf("v%0d_rd_strobes", idx), rd_strobes - rs, nr);
      check($sformatf("v%0d_beats", idx), beat_data.size() - bb, nr);
      for (int i = 0; i < nw; i++) begin
         if (wb + i < wr_addr_q.size()) begin
            ea = v.addr + ADDR_W'(i);
            check($sformatf("v%0d_wr_addr%0d", idx, i), wr_addr_q[wb+i], ea);
            check($sformatf("v%0d_wr_data%0d", idx, i), wr_data_q[wb+i], v.base + DATA_W'(i));
         end
      end
      for (int i = 0; i < nr; i++) begin
         if (bb + i < beat_data.size()) begin
            check($sformatf("v%0d_rd_data%0d", idx, i), beat_data[bb+i], v.base + DATA_W'(i));
            check($sformatf("v%0d_rd_last%0d", idx, i), beat_last[bb+i], i == n - 1);
         end
      end
      if (v.chk_lat && !exp_err) begin
         if (rise_q.size() > rb) check($sformatf("v%0d_latency", idx), rise_q[rb] - acc_cyc - 1, 2);
         else check($sformatf("v%0d_no_rd_valid", idx), 0, 1);
      end
   endtask

   vec_t vecs[8];
   vec_t rv;
   int   bb0;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 14'd2,      4'd3,  32'hA000_0000, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 14'd2,      4'd3,  32'hA000_0000, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 14'd0,      4'd15, 32'h0000_1000, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 14'd0,      4'd15, 32'h0000_1000, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 14'h3FFF,   4'd1,  32'hBEEF_0000, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 14'h3FFF,   4'd1,  32'hBEEF_0000, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 14'd9,      4'd0,  32'h0000_0055, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 14'd9,      4'd0,  32'h0000_0055, 1'b0, 1'b0, 1'b1};

      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.rd_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_enable", bus.mem_enable, 0);
      check("rst_mem_rd", bus.mem_read_enable, 0);
      check("rst_mem_wr", bus.mem_write_enable, 0);
      check("rst_mem_addr", bus.mem_address, 0);
      check("rst_mem_wdata", bus.mem_input_data, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_err", bus.err, 0);
      rst = 1'b0;
      tick();
      check("idle_req_ready", bus.req_ready, 1);
      check("idle_wr_ready", bus.wr_ready, 0);

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Reset with two reads outstanding, then a fresh load must see only new data.
      bb0 = beat_data.size();
      bus.rd_ready = 1'b0;
      request(1'b0, 14'd0, 4'd15, "rst_load");
      tick();
      rst = 1'b1;
      #1;
      check("midrst_mem_rd", bus.mem_read_enable, 0);
      check("midrst_mem_enable", bus.mem_enable, 0);
      check("midrst_rd_valid", bus.rd_valid, 0);
      check("midrst_busy", bus.busy, 0);
      tick();
      tick();
      rst = 1'b0;
      bus.rd_ready = 1'b1;
      tick();
      rv = '{1'b0, 14'd4, 4'd3, 32'h0000_1004, 1'b0, 1'b0, 1'b1};
      run_vec(8, rv);
      check("midrst_total_beats", beat_data.size() - bb0, 4);

      // New request held off while the previous load's data sits unread in the FIFO.
      bb0 = beat_data.size();
      bus.rd_ready = 1'b0;
      request(1'b0, 14'd2, 4'd1, "hold_load");
      repeat (4) tick();
      check("hold_rd_valid", bus.rd_valid, 1);
      check("hold_busy", bus.busy, 1);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 14'd9;
      bus.req_len   = 4'd0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("hold_req_ready%0d", k), bus.req_ready, 0);
         check($sformatf("hold_rd_data%0d", k), bus.rd_data, 32'h0000_1002);
         check($sformatf("hold_rd_last%0d", k), bus.rd_last, 0);
         tick();
      end
      bus.rd_ready = 1'b1;
      request(1'b0, 14'd9, 4'd0, "hold_next");
      wait_idle();
      check("hold_beats", beat_data.size() - bb0, 3);
      if (beat_data.size() - bb0 == 3) begin
         check("hold_b0_data", beat_data[bb0],   32'h0000_1002);
         check("hold_b0_last", beat_last[bb0],   0);
         check("hold_b1_data", beat_data[bb0+1], 32'h0000_1003);
         check("hold_b1_last", beat_last[bb0+1], 1);
         check("hold_b2_data", beat_data[bb0+2], 32'h0000_0055);
         check("hold_b2_last", beat_last[bb0+2], 1);
      end

      check("rw_overlap_count", overlap, 0);
      check("enable_mismatch_count", en_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
